kara_seq: RTL and testbench

- Sequencer computing a 256x256 -> 512-bit product by Karatsuba decomposition over one shared, externally instantiated sub-multiplier of (W/2+1)x(W/2+1) bits.
- Issues the three partial products z1=x1*y1, z3=x2*y2 and z2=(x1+x2)*(y1+y2) one at a time over a req/ack handshake.
- Recombines the partial products and presents z with a done pulse.
- Area-reduced alternative to a fully parallel kara_top, using the same start/x/y/z contract.

---
 rtl/kara_pkg.sv | 16 +
 rtl/kara_combine.sv | 23 ++
 rtl/kara_seq.sv | 185 ++++++++++++++++++
 tb/tb_kara_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kara_pkg.sv
// Shared constants and state encoding for the Karatsuba multiplier family.
package kara_pkg;

  localparam int KARA_W  = 256;
  localparam int KARA_H  = KARA_W / 2;
  localparam int KARA_PW = 2 * KARA_H + 2;

  typedef enum logic [2:0] {
    IDLE,
    MUL_HI,
    MUL_LO,
    MUL_MID,
    COMBINE
  } kara_state_e;

endpackage

// File: rtl/kara_combine.sv
// Karatsuba recombination: z = z1<<W + (z2-z1-z3)<<H + z3, purely combinational.
module kara_combine
  import kara_pkg::*;
#(
  parameter int W = KARA_W
) (
  input  logic [W+1:0]   z1,
  input  logic [W+1:0]   z2,
  input  logic [W+1:0]   z3,
  output logic [2*W-1:0] z
);

  localparam int H = W / 2;

  logic [W+1:0] mid;

  // The middle term equals x1*y2 + x2*y1, so it never underflows at 2H+2 bits.
  always_comb begin
    mid = z2 - z1 - z3;
    z   = ((2*W)'(z1) << W) + ((2*W)'(mid) << H) + (2*W)'(z3);
  end

endmodule

// File: rtl/kara_seq.sv
// Sequential Karatsuba multiplier sharing one external (H+1)x(H+1) sub-multiplier.
// Define KARA_SEQ_DBG_EN to expose the internal operand and partial-product registers.
module kara_seq
  import kara_pkg::*;
#(
  parameter int W = KARA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic [2*W-1:0]   z,
  output logic             busy,
  output logic             done,
  output logic             mul_req,
  output logic [W/2:0]     mul_a,
  output logic [W/2:0]     mul_b,
  input  logic             mul_ack,
  input  logic [W+1:0]     mul_p
`ifdef KARA_SEQ_DBG_EN
  ,
  output logic [W+1:0]     z1_dbg,
  output logic [W+1:0]     z2_dbg,
  output logic [W+1:0]     z3_dbg,
  output logic [W/2-1:0]   x1_dbg,
  output logic [W/2-1:0]   x2_dbg,
  output logic [W/2-1:0]   y1_dbg,
  output logic [W/2-1:0]   y2_dbg
`endif
);

  localparam int H  = W / 2;
  localparam int PW = 2 * H + 2;

  kara_state_e    state_q, state_d;
  logic           start_q;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*W-1:0] z_q, z_d, z_comb;
  logic [H-1:0]   x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic [H:0]     sx_q, sx_d, sy_q, sy_d;
  logic [PW-1:0]  z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
  logic           launch;

  kara_combine #(.W(W)) u_combine (
    .z1 (z1_q),
    .z2 (z2_q),
    .z3 (z3_q),
    .z  (z_comb)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    z_d     = z_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    z1_d    = z1_q;
    z2_d    = z2_q;
    z3_d    = z3_q;

    launch = start & ~start_q & (state_q == IDLE);
    busy_d = launch | (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (launch) begin
          x1_d    = x[W-1:H];
          x2_d    = x[H-1:0];
          y1_d    = y[W-1:H];
          y2_d    = y[H-1:0];
          sx_d    = {1'b0, x[W-1:H]} + {1'b0, x[H-1:0]};
          sy_d    = {1'b0, y[W-1:H]} + {1'b0, y[H-1:0]};
          state_d = MUL_HI;
        end
      end
      MUL_HI: begin
        if (mul_ack) begin
          z1_d    = mul_p;
          state_d = MUL_LO;
        end
      end
      MUL_LO: begin
        if (mul_ack) begin
          z3_d    = mul_p;
          state_d = MUL_MID;
        end
      end
      MUL_MID: begin
        if (mul_ack) begin
          z2_d    = mul_p;
          state_d = COMBINE;
        end
      end
      COMBINE: begin
        z_d     = z_comb;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand mux decoded from the state register keeps mul_a/mul_b stable per state.
  always_comb begin
    mul_req = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    case (state_q)
      MUL_HI: begin
        mul_req = 1'b1;
        mul_a   = {1'b0, x1_q};
        mul_b   = {1'b0, y1_q};
      end
      MUL_LO: begin
        mul_req = 1'b1;
        mul_a   = {1'b0, x2_q};
        mul_b   = {1'b0, y2_q};
      end
      MUL_MID: begin
        mul_req = 1'b1;
        mul_a   = sx_q;
        mul_b   = sy_q;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      z1_q    <= '0;
      z2_q    <= '0;
      z3_q    <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      z3_q    <= z3_d;
    end
  end

  assign z    = z_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef KARA_SEQ_DBG_EN
  assign z1_dbg = z1_q;
  assign z2_dbg = z2_q;
  assign z3_dbg = z3_q;
  assign x1_dbg = x1_q;
  assign x2_dbg = x2_q;
  assign y1_dbg = y1_q;
  assign y2_dbg = y2_q;
`endif

endmodule

// File: tb/tb_kara_seq.sv
// Self-checking bench for kara_seq: randomized operands and sub-multiplier latency,
// checked against plain x*y and the x1/y1, x2/y2, (x1+x2)/(y1+y2) request order.
`timescale 1ns/1ps
module tb_kara_seq;

  localparam int W  = 256;
  localparam int H  = W / 2;
  localparam int PW = 2 * H + 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic [2*W-1:0] z;
  logic           busy, done, mul_req;
  logic [H:0]     mul_a, mul_b;
  logic           mul_ack = 1'b0;
  logic [PW-1:0]  mul_p = '0;

  kara_seq #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .z       (z),
    .busy    (busy),
    .done    (done),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ack (mul_ack),
    .mul_p   (mul_p)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sub-multiplier model: acks after wait_cfg idle request cycles, answers a*b.
  int         wait_cfg  = 0;
  bit         stray     = 1'b0;
  int         req_cnt   = 0;
  int         ack_total = 0;
  bit         prev_hold = 1'b0;
  logic [H:0] prev_a, prev_b;
  logic [H:0] op_a_q[$];
  logic [H:0] op_b_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mul_ack   = 1'b0;
      req_cnt   = 0;
      prev_hold = 1'b0;
    end else if (mul_req) begin
      if (prev_hold) begin
        check("mul_a_stable", 512'(mul_a), 512'(prev_a));
        check("mul_b_stable", 512'(mul_b), 512'(prev_b));
      end
      if (req_cnt >= wait_cfg) begin
        mul_ack = 1'b1;
        mul_p   = PW'(mul_a) * PW'(mul_b);
        op_a_q.push_back(mul_a);
        op_b_q.push_back(mul_b);
        ack_total++;
        req_cnt   = 0;
        prev_hold = 1'b0;
      end else begin
        mul_ack   = 1'b0;
        req_cnt++;
        prev_hold = 1'b1;
        prev_a    = mul_a;
        prev_b    = mul_b;
      end
    end else begin
      mul_ack   = stray;
      mul_p     = PW'({$urandom(), $urandom(), $urandom(), $urandom()});
      req_cnt   = 0;
      prev_hold = 1'b0;
    end
  end

  // z may only change together with a done pulse (or through reset).
  int             done_cnt = 0;
  int             done_cyc = 0;
  logic [2*W-1:0] z_prev   = '0;
  bit             rst_prev = 1'b0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst_n && rst_prev && !done) check("z_hold", z, z_prev);
    z_prev   = z;
    rst_prev = rst_n;
  end

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic wait_done(input string tag, input int dc0, input int bound);
    int n = 0;
    while (done_cnt == dc0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, 512'(done_cnt - dc0), 512'(1));
  endtask

  task automatic check_ops(input string tag, input logic [W-1:0] xa, input logic [W-1:0] ya);
    logic [H:0] ea[3];
    logic [H:0] eb[3];
    ea[0] = (H+1)'(xa >> H);
    eb[0] = (H+1)'(ya >> H);
    ea[1] = (H+1)'(xa[H-1:0]);
    eb[1] = (H+1)'(ya[H-1:0]);
    ea[2] = ea[0] + ea[1];
    eb[2] = eb[0] + eb[1];
    check({tag, "_op_count"}, 512'(op_a_q.size()), 512'(3));
    for (int i = 0; i < 3 && i < op_a_q.size(); i++) begin
      check($sformatf("%s_mul_a%0d", tag, i), 512'(op_a_q[i]), 512'(ea[i]));
      check($sformatf("%s_mul_b%0d", tag, i), 512'(op_b_q[i]), 512'(eb[i]));
    end
  endtask

  // One complete operation with a fixed ack wait; checks result, latency and request order.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                        input int wcfg, input bit stray_en, input string tag);
    int dc0, t0;
    wait_cfg = wcfg;
    stray    = stray_en;
    op_a_q.delete();
    op_b_q.delete();
    dc0 = done_cnt;
    @(negedge clk);
    #1;
    x = xa;
    y = ya;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    #1;
    start = 1'b0;
    x = ~xa;
    y = rand_w();
    check({tag, "_busy_c1"}, 512'(busy), 512'(1));
    wait_done(tag, dc0, 400);
    check({tag, "_latency"}, 512'(done_cyc - t0), 512'(5 + 3 * wcfg));
    check({tag, "_z"}, z, 512'(xa) * 512'(ya));
    check_ops(tag, xa, ya);
    check({tag, "_busy_done"}, 512'(busy), 512'(1));
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, 512'(done), 512'(0));
    check({tag, "_busy_end"}, 512'(busy), 512'(0));
    stray = 1'b0;
  endtask

  initial begin
    logic [W-1:0]   xa, ya, xb, xc, yc;
    logic [2*W-1:0] z_keep;
    int             dc0, a0, n;

    #2 rst_n = 1'b0;
    #1;
    check("rst_z", z, 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    check("rst_mul_req", 512'(mul_req), 512'(0));
    check("rst_mul_a", 512'(mul_a), 512'(0));
    check("rst_mul_b", 512'(mul_b), 512'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2^128+1 squared, zero-wait ack
    xa = '0;
    xa[128] = 1'b1;
    xa[0]   = 1'b1;
    run_op(xa, xa, 0, 1'b0, "t1");

    // all ones, ack on the third request cycle of each product
    xa = '1;
    run_op(xa, xa, 2, 1'b0, "t2");

    // bring-up vector with start held high
    xa = '0;
    xa[W-1 -: 16] = 16'h0111;
    xa[15:0]      = 16'h0f00;
    wait_cfg = 1;
    dc0 = done_cnt;
    @(negedge clk);
    #1;
    x = xa;
    y = xa;
    start = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    check("t3_one_done", 512'(done_cnt - dc0), 512'(1));
    check("t3_z", z, 512'(xa) * 512'(xa));
    start = 1'b0;
    @(negedge clk);

    // edge while busy is dropped; edge after done launches
    xa = rand_w();
    xb = rand_w();
    xc = rand_w();
    yc = rand_w();
    wait_cfg = 3;
    dc0 = done_cnt;
    @(negedge clk);
    #1;
    x = xa;
    y = xa;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    #1;
    x = xb;
    y = xb;
    start = 1'b1;
    wait_done("t4a", dc0, 200);
    check("t4a_z", z, 512'(xa) * 512'(xa));
    repeat (30) @(negedge clk);
    #1;
    check("t4_no_queue", 512'(done_cnt - dc0), 512'(1));
    check("t4_idle", 512'(busy), 512'(0));
    start = 1'b0;
    run_op(xc, yc, 3, 1'b0, "t4c");

    // reset while in MUL_MID
    wait_cfg = 4;
    a0 = ack_total;
    @(negedge clk);
    #1;
    x = rand_w();
    y = rand_w();
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(ack_total == a0 + 2 && mul_req && !mul_ack) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_reached_mid", 512'(ack_total - a0), 512'(2));
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_z", z, 512'(0));
    check("t5_rst_busy", 512'(busy), 512'(0));
    check("t5_rst_req", 512'(mul_req), 512'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_op(256'd3, 256'd5, 0, 1'b0, "t5_after");

    // stray acks in IDLE
    stray = 1'b1;
    dc0 = done_cnt;
    z_keep = z;
    repeat (10) @(negedge clk);
    #1;
    check("t6_idle_busy", 512'(busy), 512'(0));
    check("t6_idle_done", 512'(done_cnt - dc0), 512'(0));
    check("t6_idle_z", z, z_keep);
    stray = 1'b0;

    // stray acks present around every operation, including COMBINE
    run_op(rand_w(), rand_w(), 1, 1'b1, "t6_comb");

    for (int i = 0; i < 8; i++) begin
      run_op(rand_w(), rand_w(), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
